pattern_control: RTL and testbench

- Control stage that sits directly upstream of the LED pattern generator and replaces its raw key decode and fixed divider.
- Debounces the push keys and turns presses into a registered pattern mode and a speed setting.
- Generates the one-cycle step enable pulse that advances the patterns, with a selectable rate and a pause function.
- Outputs feed the pattern generator's mode select and step enable directly.

---
 rtl/pattern_control.sv | 156 +++++++++++++++
 tb/tb_pattern_control.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_control.sv
// pattern_control: key conditioning and step-rate control for the LED pattern
// generator. Raw keys are synchronized and debounced, debounced rising edges
// become one-cycle press pulses, and those pulses drive the mode, speed and
// pause registers. A power-of-two divider produces the step_en pulse.
module pattern_control #(
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter int unsigned BASE_PERIOD     = 16777216,
    parameter logic [2:0]  RESET_SPEED     = 3'd0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [4:0] key,
    output logic [1:0] mode,
    output logic [2:0] speed,
    output logic       paused,
    output logic       step_en,
    output logic [4:0] key_press
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PW = $clog2(BASE_PERIOD);

    localparam int unsigned KEY_NEXT  = 0;
    localparam int unsigned KEY_PREV  = 1;
    localparam int unsigned KEY_UP    = 2;
    localparam int unsigned KEY_DOWN  = 3;
    localparam int unsigned KEY_PAUSE = 4;

    localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PERIOD_ONES = '1;
    localparam logic [2:0]    SPEED_MAX   = 3'd7;

    // synchronizer, debounce and press-detect state
    logic [4:0]         sync1_q;
    logic [4:0]         sync2_q;
    logic [4:0]         db_q;
    logic [4:0]         db_d;
    logic [4:0]         db_dly_q;
    logic [4:0][CW-1:0] cnt_q;
    logic [4:0][CW-1:0] cnt_d;
    logic [4:0]         press_q;

    // control state
    logic [1:0]    mode_q;
    logic [1:0]    mode_d;
    logic [2:0]    speed_q;
    logic [2:0]    speed_d;
    logic          speed_chg;
    logic          paused_q;
    logic          paused_d;
    logic [PW-1:0] div_q;
    logic [PW-1:0] div_d;
    logic [PW-1:0] period_m1;
    logic          step_q;
    logic          step_d;

    // two-flop synchronizer on every raw key
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= key;
            sync2_q <= sync1_q;
        end
    end

    // per-key debounce: count consecutive disagreeing cycles, flip level on the last one
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // debounced levels and registered press pulses on debounced 0->1 flips
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            db_q     <= '0;
            cnt_q    <= '0;
            db_dly_q <= '0;
            press_q  <= '0;
        end else begin
            db_q     <= db_d;
            cnt_q    <= cnt_d;
            db_dly_q <= db_q;
            press_q  <= db_q & ~db_dly_q;
        end
    end

    // mode/speed/pause updates and divider next state from the press pulses
    always_comb begin
        mode_d = mode_q;
        case ({press_q[KEY_PREV], press_q[KEY_NEXT]})
            2'b01:   mode_d = mode_q + 2'd1;
            2'b10:   mode_d = mode_q - 2'd1;
            default: mode_d = mode_q;
        endcase

        speed_d = speed_q;
        case ({press_q[KEY_DOWN], press_q[KEY_UP]})
            2'b01:   if (speed_q != SPEED_MAX) speed_d = speed_q + 3'd1;
            2'b10:   if (speed_q != 3'd0)      speed_d = speed_q - 3'd1;
            default: speed_d = speed_q;
        endcase
        speed_chg = (speed_d != speed_q);

        paused_d = paused_q ^ press_q[KEY_PAUSE];

        // BASE_PERIOD is a power of two, so P-1 is an all-ones mask shifted by speed
        period_m1 = PERIOD_ONES >> speed_q;
        div_d     = div_q;
        step_d    = 1'b0;
        if (speed_chg) begin
            div_d = '0;
        end else if (!paused_q) begin
            if (div_q == period_m1) begin
                div_d  = '0;
                step_d = 1'b1;
            end else begin
                div_d = div_q + PW'(1);
            end
        end
    end

    // control and divider registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_q   <= '0;
            speed_q  <= RESET_SPEED;
            paused_q <= 1'b0;
            div_q    <= '0;
            step_q   <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            speed_q  <= speed_d;
            paused_q <= paused_d;
            div_q    <= div_d;
            step_q   <= step_d;
        end
    end

    assign mode      = mode_q;
    assign speed     = speed_q;
    assign paused    = paused_q;
    assign step_en   = step_q;
    assign key_press = press_q;

endmodule

// File: tb/tb_pattern_control.sv
// Testbench for pattern_control: a behavioural model predicts every output
// event (pulse or state change) per clock edge and queues it; a monitor
// compares the DUT's observed events against the queue.
module tb_pattern_control;

    localparam int unsigned DC = 4;
    localparam int unsigned BP = 256;
    localparam int          RS = 0;

    logic       clock;
    logic       reset_n;
    logic [4:0] key;
    logic [1:0] mode;
    logic [2:0] speed;
    logic       paused;
    logic       step_en;
    logic [4:0] key_press;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    pattern_control #(
        .DEBOUNCE_CYCLES(DC),
        .BASE_PERIOD    (BP),
        .RESET_SPEED    (3'(RS))
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .key      (key),
        .mode     (mode),
        .speed    (speed),
        .paused   (paused),
        .step_en  (step_en),
        .key_press(key_press)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int       cyc;
        int       mode;
        int       speed;
        bit       paused;
        bit       step;
        bit [4:0] kp;
    } rec_t;

    rec_t exp_q[$];

    // ---------------- reference model ----------------
    bit [4:0] m_sh1 = '0, m_sh2 = '0, m_lvl = '0, m_rise = '0, m_kp = '0;
    int       m_run [5] = '{0, 0, 0, 0, 0};
    int       m_mode = 0, m_speed = RS, m_phase = 0;
    bit       m_paused = 0, m_step = 0;

    always @(posedge clock) begin
        int       n_mode, n_speed, n_phase, per;
        bit       n_paused, n_step, moved;
        bit [4:0] n_kp, n_rise;
        rec_t     r;
        cyc++;
        if (!reset_n) begin
            n_mode = 0; n_speed = RS; n_paused = 0; n_step = 0; n_kp = '0;
            m_sh1 = '0; m_sh2 = '0; m_lvl = '0; m_rise = '0; m_phase = 0;
            for (int i = 0; i < 5; i++) m_run[i] = 0;
        end else begin
            // press pulses visible before this edge act on the control state
            n_mode = m_mode;
            if (m_kp[0] && !m_kp[1]) n_mode = (m_mode + 1) % 4;
            if (m_kp[1] && !m_kp[0]) n_mode = (m_mode + 3) % 4;
            n_speed = m_speed;
            if (m_kp[2] && !m_kp[3] && m_speed < 7) n_speed = m_speed + 1;
            if (m_kp[3] && !m_kp[2] && m_speed > 0) n_speed = m_speed - 1;
            moved    = (n_speed != m_speed);
            n_paused = m_paused ^ m_kp[4];
            per      = BP / (1 << m_speed);
            n_step   = 0;
            if (moved) m_phase = 0;
            else if (!m_paused) begin
                m_phase++;
                if (m_phase == per) begin
                    m_phase = 0;
                    n_step  = 1;
                end
            end
            // a debounced rise becomes a pulse one edge later
            n_kp   = m_rise;
            n_rise = '0;
            for (int i = 0; i < 5; i++) begin
                if (m_sh2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DC) begin
                        m_lvl[i]  = m_sh2[i];
                        m_run[i]  = 0;
                        n_rise[i] = m_sh2[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_rise = n_rise;
            m_sh2  = m_sh1;
            m_sh1  = key;
        end
        if (n_step || n_kp != 0 || n_mode != m_mode || n_speed != m_speed || n_paused != m_paused) begin
            r.cyc = cyc; r.mode = n_mode; r.speed = n_speed; r.paused = n_paused;
            r.step = n_step; r.kp = n_kp;
            exp_q.push_back(r);
        end
        m_mode = n_mode; m_speed = n_speed; m_paused = n_paused; m_step = n_step; m_kp = n_kp;
    end

    // ---------------- monitor ----------------
    int pm = 0, ps = RS;
    bit pp = 0;

    always begin
        bit   dut_ev, exp_ev;
        rec_t e;
        @(posedge clock);
        #1;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++; fails++;
            $display("FAIL missing_event: cycle %0d expected step=%0d kp=%b mode=%0d speed=%0d paused=%0d, nothing seen",
                     e.cyc, e.step, e.kp, e.mode, e.speed, e.paused);
        end
        dut_ev = step_en || key_press != 0 || int'(mode) != pm || int'(speed) != ps || paused != pp;
        exp_ev = exp_q.size() > 0 && exp_q[0].cyc == cyc;
        if (dut_ev || exp_ev) begin
            checks++;
            if (!exp_ev) begin
                fails++;
                $display("FAIL unexpected_event: cycle %0d got step=%0d kp=%b mode=%0d speed=%0d paused=%0d, required no event",
                         cyc, step_en, key_press, mode, speed, paused);
            end else begin
                e = exp_q.pop_front();
                if (step_en != e.step || key_press != e.kp || int'(mode) != e.mode ||
                    int'(speed) != e.speed || paused != e.paused) begin
                    fails++;
                    $display("FAIL event: cycle %0d got step=%0d kp=%b mode=%0d speed=%0d paused=%0d, required step=%0d kp=%b mode=%0d speed=%0d paused=%0d",
                             cyc, step_en, key_press, mode, speed, paused,
                             e.step, e.kp, e.mode, e.speed, e.paused);
                end
            end
        end
        pm = int'(mode); ps = int'(speed); pp = paused;
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic press(input bit [4:0] k);
        key = k;
        idle(12);
        key = '0;
        idle(12);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mode"},      int'(mode), 0);
        check({tag, "_speed"},     int'(speed), RS);
        check({tag, "_paused"},    int'(paused), 0);
        check({tag, "_step_en"},   int'(step_en), 0);
        check({tag, "_key_press"}, int'(key_press), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        key     = '0;
        idle(3);
        check_reset_values("reset");
        reset_n = 1'b1;

        // free-running divider at speed 0
        idle(800);

        // short glitch is ignored, then a real press and three more
        key = 5'b00001; idle(3); key = '0; idle(20);
        check("glitch_mode", int'(mode), 0);
        key = 5'b00001; idle(20); key = '0; idle(12);
        check("mode_after_next", int'(mode), 1);
        for (int i = 0; i < 3; i++) press(5'b00001);
        check("mode_wrap", int'(mode), 0);

        // speed up nine times (saturates), then down eight times
        for (int i = 0; i < 9; i++) begin press(5'b00100); idle(280); end
        check("speed_sat_high", int'(speed), 7);
        for (int i = 0; i < 8; i++) begin press(5'b01000); idle(280); end
        check("speed_sat_low", int'(speed), 0);

        // opposing keys together cancel
        press(5'b00011);
        check("mode_cancel", int'(mode), 0);
        press(5'b01100);
        check("speed_cancel", int'(speed), 0);

        // pause, stay silent a while, resume
        idle(77);
        press(5'b10000);
        check("paused_set", int'(paused), 1);
        idle(1000);
        press(5'b10000);
        check("paused_clr", int'(paused), 0);
        idle(300);

        // move away from reset values, then reset mid-debounce and mid-period
        press(5'b00001);
        press(5'b00100);
        idle(40);
        key = 5'b00001;
        idle(4);
        reset_n = 1'b0;
        key     = '0;
        #1;
        check_reset_values("midreset");
        idle(1);
        reset_n = 1'b1;
        idle(600);

        // randomized key activity
        for (int i = 0; i < 250; i++) begin
            key = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'(1 << $urandom_range(0, 4));
            idle($urandom_range(1, 12));
            if ($urandom_range(0, 2) == 0) begin
                key = '0;
                idle($urandom_range(1, 12));
            end
        end
        key = '0;
        idle(60);

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
